ptp_ts_monitor: RTL

- Passive checker/consumer for the PTP time interface driven by a PTP clock: ts_96 (48b sec, 30b ns, 16b frac ns), ts_64 (48b ns, 16b frac ns) and pps.
- Samples all three every cycle and checks ts_96 format, monotonicity of both timestamps, per-cycle step size, and pairing of pps with the ts_96 seconds rollover.
- Reports sticky error flags, a pps-aligned timestamp capture and a pps count.
- Sits beside the PTP clock in testbenches and on-chip as a health monitor.

---
 rtl/ptp_ts_pkg.sv | 34 +++
 rtl/ptp_pps_pair.sv | 96 +++++++++
 rtl/ptp_ts_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ptp_ts_pkg.sv
// Shared definitions for the PTP timestamp monitor.
// Provides timestamp field layout, the seconds length in ns and the
// pps/rollover pairing state encoding.
package ptp_ts_pkg;

   localparam int unsigned TS96_W      = 96;
   localparam int unsigned TS64_W      = 64;
   localparam int unsigned SEC_W       = 48;
   localparam int unsigned NS_W        = 30;
   localparam int unsigned FNS_W       = 16;
   localparam int unsigned RSVD_W      = 2;
   localparam int unsigned KEY96_W     = SEC_W + NS_W + FNS_W;
   localparam int unsigned TS64_NS_LSB = 16;
   localparam int unsigned TS64_NS_W   = 48;
   localparam int unsigned CNT_W       = 32;
   localparam int unsigned WIN_W       = 8;
   localparam int unsigned NS_PER_SEC  = 1_000_000_000;

   // Time-of-day timestamp layout; rsvd bits carry no time information
   typedef struct packed {
      logic [SEC_W-1:0]  sec;
      logic [RSVD_W-1:0] rsvd;
      logic [NS_W-1:0]   ns;
      logic [FNS_W-1:0]  fns;
   } ts96_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_PPS  = 2'd1,
      ST_WAIT_ROLL = 2'd2,
      ST_MATCH     = 2'd3
   } pair_state_t;

endpackage

// File: rtl/ptp_pps_pair.sv
// Pairs pps rising edges with seconds rollovers inside a cycle window.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   roll_evt  - ts_96 seconds field changed this cycle
//   pps_evt   - registered pps rose this cycle
//   match     - one cycle after a successful pairing
//   err       - pairing failure detected this cycle (unpaired or repeated event)
//   locked    - two consecutive pairings seen without a failure
module ptp_pps_pair
   import ptp_ts_pkg::*;
#(
   parameter int unsigned PPS_WINDOW = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic roll_evt,
   input  logic pps_evt,
   output logic match,
   output logic err,
   output logic locked
);

   pair_state_t      state;
   pair_state_t      state_nxt;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_cnt_nxt;
   logic [WIN_W-1:0] elapsed;
   logic [1:0]       lock_cnt;
   logic             waiting;
   logic             timeout;
   logic             awaited;
   logic             repeated;

   // Cycles since the first event of a pending pair, counting this one
   assign elapsed  = win_cnt + WIN_W'(1);
   assign waiting  = (state == ST_WAIT_PPS) || (state == ST_WAIT_ROLL);
   assign timeout  = elapsed >= WIN_W'(PPS_WINDOW);
   assign awaited  = (state == ST_WAIT_PPS) ? pps_evt  : roll_evt;
   assign repeated = (state == ST_WAIT_PPS) ? roll_evt : pps_evt;

   // State register plus window and lock tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         win_cnt  <= '0;
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         state   <= state_nxt;
         win_cnt <= win_cnt_nxt;
         if (err) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
         end else if (state == ST_MATCH) begin
            if (lock_cnt != 2'd2) lock_cnt <= lock_cnt + 2'd1;
            if (lock_cnt != 2'd0) locked <= 1'b1;
         end
      end
   end

   // Next-state logic; MATCH evaluates new events exactly like IDLE
   always_comb begin
      state_nxt   = state;
      win_cnt_nxt = win_cnt;
      case (state)
         ST_IDLE, ST_MATCH: begin
            win_cnt_nxt = '0;
            if (roll_evt && pps_evt) state_nxt = ST_MATCH;
            else if (roll_evt)       state_nxt = ST_WAIT_PPS;
            else if (pps_evt)        state_nxt = ST_WAIT_ROLL;
            else                     state_nxt = ST_IDLE;
         end
         default: begin
            win_cnt_nxt = elapsed;
            if (timeout) begin
               state_nxt   = ST_IDLE;
               win_cnt_nxt = '0;
            end else if (awaited) begin
               state_nxt   = ST_MATCH;
               win_cnt_nxt = '0;
            end else if (repeated) begin
               win_cnt_nxt = '0;
            end
         end
      endcase
   end

   // Outputs; err is decided in the same cycle as the offending event
   always_comb begin
      match = 1'b0;
      err   = 1'b0;
      if (state == ST_MATCH) match = 1'b1;
      if (waiting) err = timeout || (!awaited && repeated);
   end

endmodule

// File: rtl/ptp_ts_monitor.sv
// Passive health monitor for a PTP time interface.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   ts_96        - {sec[95:48], rsvd[47:46], ns[45:16], fns[15:0]}
//   ts_64        - {ns[63:16], fns[15:0]}
//   pps          - pulse per second
//   clear        - clears the sticky error flags
//   fmt_err, mono_err_96, mono_err_64, step_err, pps_err - sticky flags
//   pps_locked   - two consecutive pps/rollover pairings
//   pps_ts       - ts_96 captured on each pps rising edge
//   pps_ts_valid - one-cycle pulse with each capture
//   pps_count    - number of paired pps events (wraps)
module ptp_ts_monitor
   import ptp_ts_pkg::*;
#(
   parameter int unsigned MAX_STEP_NS = 16,
   parameter int unsigned PPS_WINDOW  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TS96_W-1:0] ts_96,
   input  logic [TS64_W-1:0] ts_64,
   input  logic              pps,
   input  logic              clear,
   output logic              fmt_err,
   output logic              mono_err_96,
   output logic              mono_err_64,
   output logic              step_err,
   output logic              pps_err,
   output logic              pps_locked,
   output logic [TS96_W-1:0] pps_ts,
   output logic              pps_ts_valid,
   output logic [CNT_W-1:0]  pps_count
);

   ts96_t                s1_96;
   logic [TS64_W-1:0]    s1_64;
   logic                 s1_pps;
   logic                 s1_valid;
   logic [KEY96_W-1:0]   prev_key;
   logic [TS64_W-1:0]    prev_64;
   logic                 prev_pps;
   logic                 prev_valid;
   logic [KEY96_W-1:0]   cur_key;
   logic [TS64_NS_W-1:0] delta_ns;
   logic                 fmt_bad;
   logic                 mono96_bad;
   logic                 mono64_bad;
   logic                 step_bad;
   logic                 roll_evt;
   logic                 pps_evt;
   logic                 pair_match;
   logic                 pair_err;

   // Stage 1 input sample and the previous sample it is judged against
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_96      <= '0;
         s1_64      <= '0;
         s1_pps     <= 1'b0;
         s1_valid   <= 1'b0;
         prev_key   <= '0;
         prev_64    <= '0;
         prev_pps   <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         s1_96      <= ts_96;
         s1_64      <= ts_64;
         s1_pps     <= pps;
         s1_valid   <= 1'b1;
         prev_key   <= cur_key;
         prev_64    <= s1_64;
         prev_pps   <= s1_pps;
         prev_valid <= s1_valid;
      end
   end

   // Ordering key skips the reserved bits between sec and ns
   assign cur_key = {s1_96.sec, s1_96.ns, s1_96.fns};

   // Integer-ns part of the 64-bit modular difference, borrow from fns included
   assign delta_ns = s1_64[TS64_W-1:TS64_NS_LSB] - prev_64[TS64_W-1:TS64_NS_LSB]
                   - TS64_NS_W'(s1_64[TS64_NS_LSB-1:0] < prev_64[TS64_NS_LSB-1:0]);

   // Per-sample checks; backward steps are reported only as monotonic errors
   assign fmt_bad    = s1_valid && (s1_96.ns >= NS_W'(NS_PER_SEC));
   assign mono96_bad = prev_valid && (cur_key <= prev_key);
   assign mono64_bad = prev_valid && (s1_64 <= prev_64);
   assign step_bad   = prev_valid && !mono64_bad && (delta_ns > TS64_NS_W'(MAX_STEP_NS));
   assign roll_evt   = prev_valid && (s1_96.sec != prev_key[KEY96_W-1 -: SEC_W]);
   assign pps_evt    = s1_valid && s1_pps && !prev_pps;

   ptp_pps_pair #(
      .PPS_WINDOW (PPS_WINDOW)
   ) u_pair (
      .clk      (clk),
      .rst      (rst),
      .roll_evt (roll_evt),
      .pps_evt  (pps_evt),
      .match    (pair_match),
      .err      (pair_err),
      .locked   (pps_locked)
   );

   // Sticky flags (a new error beats clear), pps capture and pairing count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fmt_err      <= 1'b0;
         mono_err_96  <= 1'b0;
         mono_err_64  <= 1'b0;
         step_err     <= 1'b0;
         pps_err      <= 1'b0;
         pps_ts       <= '0;
         pps_ts_valid <= 1'b0;
         pps_count    <= '0;
      end else begin
         fmt_err      <= (fmt_err     && !clear) || fmt_bad;
         mono_err_96  <= (mono_err_96 && !clear) || mono96_bad;
         mono_err_64  <= (mono_err_64 && !clear) || mono64_bad;
         step_err     <= (step_err    && !clear) || step_bad;
         pps_err      <= (pps_err     && !clear) || pair_err;
         pps_ts_valid <= pps_evt;
         if (pps_evt) pps_ts <= s1_96;
         pps_count    <= pps_count + CNT_W'(pair_match);
      end
   end

endmodule
